// File: rtl/dmem_cache.sv
// rtl/dmem_cache.sv - direct-mapped write-back, write-allocate data cache with 256-bit lines
module dmem_cache #(
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 27 - IW;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

    state_t          state;
    logic [SETS-1:0] valid_arr;
    logic [SETS-1:0] dirty_arr;
    logic [TW-1:0]   tag_arr  [SETS];
    logic [255:0]    data_arr [SETS];
    // Line address of the request being serviced; kept so a fill completes correctly
    // even if the CPU drops or changes its request mid-transaction.
    logic [26:0]     req_line;

    logic            req;
    logic            hit;
    logic            store_hit;
    logic [IW-1:0]   cpu_idx;
    logic [TW-1:0]   cpu_tag;
    logic [2:0]      cpu_off;
    logic [IW-1:0]   req_idx;
    logic [TW-1:0]   req_tag;
    logic [31:0]     line_word;
    logic [31:0]     store_word;
    logic            unused_addr_bits;

    assign req              = mem_read | mem_write;
    assign cpu_idx          = mem_address[5 +: IW];
    assign cpu_tag          = mem_address[31 -: TW];
    assign cpu_off          = mem_address[4:2];
    assign req_idx          = req_line[IW-1:0];
    assign req_tag          = req_line[26 -: TW];
    assign unused_addr_bits = &{1'b0, mem_address[1:0]};

    assign hit       = valid_arr[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
    assign line_word = data_arr[cpu_idx][{cpu_off, 5'b0} +: 32];
    assign store_hit = (state == COMPARE) && mem_write && hit;

    always_comb begin
        store_word = line_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                store_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
        end
    end

    // All outputs decode from the state register, so the async reset clears them at once.
    assign mem_resp   = (state == COMPARE) && req && hit;
    assign mem_rdata  = mem_resp ? line_word : 32'h0;
    assign pmem_read  = (state == FILL);
    assign pmem_write = (state == WRITEBACK);
    assign pmem_wdata = (state == WRITEBACK) ? data_arr[req_idx] : 256'h0;

    always_comb begin
        pmem_address = 32'h0;
        if (state == WRITEBACK) begin
            pmem_address = {tag_arr[req_idx], req_idx, 5'b0};
        end else if (state == FILL) begin
            pmem_address = {req_line, 5'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            valid_arr <= '0;
            dirty_arr <= '0;
            req_line  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    req_line <= mem_address[31:5];
                    if (!req || hit) begin
                        state <= IDLE;
                    end else if (valid_arr[cpu_idx] && dirty_arr[cpu_idx]) begin
                        state <= WRITEBACK;
                    end else begin
                        state <= FILL;
                    end
                    if (store_hit) begin
                        dirty_arr[cpu_idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid_arr[req_idx] <= 1'b1;
                        dirty_arr[req_idx] <= 1'b0;
                        state              <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store_hit) begin
            data_arr[cpu_idx][{cpu_off, 5'b0} +: 32] <= store_word;
        end
        if ((state == FILL) && pmem_resp) begin
            data_arr[req_idx] <= pmem_rdata;
            tag_arr[req_idx]  <= req_tag;
        end
    end
endmodule

// File: tb/tb_dmem_cache.sv
// tb/tb_dmem_cache.sv - scoreboard bench for dmem_cache with a line-memory responder
module tb_dmem_cache;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_address = 32'h0;
    logic [31:0]  mem_wdata = 32'h0;
    logic [3:0]   mem_byte_enable = 4'h0;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = 256'h0;
    logic         pmem_resp = 1'b0;

    dmem_cache #(.SETS(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];

    int mem_lat = 2;
    int lat_cnt = 0;
    int ev_n = 0;
    int wb_cnt = 0;
    int fill_cnt = 0;
    int wb_seq = 0;
    int fill_seq = 0;
    logic [31:0]  wb_addr = 32'h0;
    logic [255:0] wb_data = 256'h0;
    logic [31:0]  fill_addr = 32'h0;
    logic [255:0] stored_line = 256'h0;
    logic [31:0]  stored_addr = 32'h0;
    logic         stored_vld = 1'b0;

    int resp_cnt = 0;
    int busy_cnt = 0;
    int both_cnt = 0;
    int misalign_cnt = 0;
    int leak_cnt = 0;

    // Backing memory: word k of line a is k*0x1111_1111 + (a - 0x1040); the last written-back line overrides.
    function automatic logic [255:0] default_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            l[k*32 +: 32] = 32'(k) * 32'h1111_1111 + (a - 32'h0000_1040);
        end
        return l;
    endfunction

    always @(posedge clk) begin
        pmem_resp <= 1'b0;
        if ((pmem_read || pmem_write) && !pmem_resp) begin
            if (lat_cnt == mem_lat) begin
                pmem_resp <= 1'b1;
                lat_cnt   <= 0;
                ev_n      <= ev_n + 1;
                if (pmem_write) begin
                    wb_addr     <= pmem_address;
                    wb_data     <= pmem_wdata;
                    wb_cnt      <= wb_cnt + 1;
                    wb_seq      <= ev_n;
                    stored_line <= pmem_wdata;
                    stored_addr <= pmem_address;
                    stored_vld  <= 1'b1;
                end else begin
                    fill_addr  <= pmem_address;
                    fill_cnt   <= fill_cnt + 1;
                    fill_seq   <= ev_n;
                    pmem_rdata <= (stored_vld && stored_addr == pmem_address) ? stored_line
                                                                              : default_line(pmem_address);
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            lat_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (mem_resp) resp_cnt <= resp_cnt + 1;
        if (pmem_read || pmem_write) begin
            busy_cnt <= busy_cnt + 1;
            if (pmem_address[4:0] != 5'h0) misalign_cnt <= misalign_cnt + 1;
        end
        if (pmem_read && pmem_write) both_cnt <= both_cnt + 1;
        if (!mem_resp && mem_rdata != 32'h0) leak_cnt <= leak_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 with the request lowered. exp_lat < 0 skips the latency check.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp, input int exp_lat, input string tag);
        int cyc;
        bit got;
        logic [31:0] e;
        exp_q.push_back(exp);
        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_wdata = wd;
        mem_byte_enable = be;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (mem_resp) begin
                got = 1'b1;
                e = exp_q.pop_front();
                if (rd && !wr) check_eq({tag, "_rdata"}, mem_rdata, e);
            end
        end
        if (!got) begin
            check_eq({tag, "_resp_timeout"}, 32'(got), 32'h1);
            void'(exp_q.pop_front());
        end else if (exp_lat >= 0) begin
            check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic wait_pmem_read(input string tag);
        int t;
        t = 0;
        while (!pmem_read && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_pmem_read_seen"}, 32'(pmem_read), 32'h1);
    endtask

    int b0, f0, w0, r0, t;
    logic [31:0] e;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mem_resp", 32'(mem_resp), 32'h0);
        check_eq("rst_mem_rdata", mem_rdata, 32'h0);
        check_eq("rst_pmem_rw", 32'({pmem_read, pmem_write}), 32'h0);
        check_eq("rst_pmem_address", pmem_address, 32'h0);
        check_eq("rst_pmem_wdata", 32'(|pmem_wdata), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        do_req(1, 0, 32'h0000_1050, 0, 0, 32'h4444_4444, mem_lat + 2 + 3, "cold_load");
        check_eq("cold_fill_addr", fill_addr, 32'h0000_1040);
        check_eq("cold_fill_cnt", 32'(fill_cnt), 32'h1);
        check_eq("cold_wb_cnt", 32'(wb_cnt), 32'h0);

        b0 = busy_cnt;
        do_req(0, 1, 32'h0000_1050, 32'hAABB_CCDD, 4'b0011, 32'h0, 2, "store_hit");
        do_req(1, 0, 32'h0000_1050, 0, 0, 32'h4444_CCDD, 2, "load_after_store");
        for (int k = 0; k < 8; k++) begin
            e = (k == 4) ? 32'h4444_CCDD : 32'(k) * 32'h1111_1111;
            do_req(1, 0, 32'h0000_1040 + 32'(k * 4), 0, 0, e, 2, $sformatf("word%0d", k));
        end
        check_eq("hits_no_pmem", 32'(busy_cnt - b0), 32'h0);

        do_req(1, 0, 32'h0000_2050, 0, 0, 32'h4444_5444, -1, "dirty_miss");
        check_eq("wb_cnt", 32'(wb_cnt), 32'h1);
        check_eq("wb_addr", wb_addr, 32'h0000_1040);
        check_eq("wb_word4", wb_data[4*32 +: 32], 32'h4444_CCDD);
        check_eq("wb_word7", wb_data[7*32 +: 32], 32'h7777_7777);
        check_eq("dm_fill_addr", fill_addr, 32'h0000_2040);
        check_eq("wb_before_fill", 32'(wb_seq < fill_seq), 32'h1);

        do_req(1, 0, 32'h0000_1050, 0, 0, 32'h4444_CCDD, mem_lat + 2 + 3, "refill_clean");
        check_eq("refill_wb_cnt", 32'(wb_cnt), 32'h1);

        mem_lat = 4;
        f0 = fill_cnt;
        mem_read = 1'b1;
        mem_address = 32'h0000_2050;
        wait_pmem_read("rst_fill");
        @(posedge clk);
        #1;
        check_eq("pre_rst_pmem_read", 32'(pmem_read), 32'h1);
        rst = 1'b0;
        #1;
        check_eq("rst_drops_pmem_read", 32'(pmem_read), 32'h0);
        check_eq("rst_drops_addr", pmem_address, 32'h0);
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_eq("rst_no_fill_done", 32'(fill_cnt - f0), 32'h0);
        do_req(1, 0, 32'h0000_2050, 0, 0, 32'h4444_5444, mem_lat + 2 + 3, "post_rst_load");
        check_eq("post_rst_refetch", 32'(fill_cnt - f0), 32'h1);
        check_eq("post_rst_fill_addr", fill_addr, 32'h0000_2040);

        f0 = fill_cnt;
        w0 = wb_cnt;
        r0 = resp_cnt;
        mem_read = 1'b1;
        mem_address = 32'h0000_1050;
        wait_pmem_read("drop_fill");
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        t = 0;
        while (fill_cnt == f0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("drop_fill_done", 32'(fill_cnt - f0), 32'h1);
        repeat (4) @(negedge clk);
        check_eq("drop_no_resp", 32'(resp_cnt - r0), 32'h0);
        check_eq("drop_no_wb", 32'(wb_cnt - w0), 32'h0);
        @(posedge clk);
        #1;
        b0 = busy_cnt;
        do_req(1, 0, 32'h0000_1050, 0, 0, 32'h4444_CCDD, 2, "after_drop_hit");
        check_eq("after_drop_no_pmem", 32'(busy_cnt - b0), 32'h0);

        repeat (2) @(negedge clk);
        check_eq("never_rd_and_wr", 32'(both_cnt), 32'h0);
        check_eq("pmem_addr_aligned", 32'(misalign_cnt), 32'h0);
        check_eq("rdata_zero_idle", 32'(leak_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
